// File: rtl/mem_wb_reg_pkg.sv
// Shared definitions for the MEM->WB pipeline register: writeback-select encodings and bubble
// constants. The optional trace feature (WB_TRACE_EN) adds no definitions here.
package mem_wb_reg_pkg;

  typedef enum logic [1:0] {
    WdSextExt = 2'b00,
    WdAluC    = 2'b01,
    WdNpcPc4  = 2'b10,
    WdDramRd  = 2'b11
  } wd_sel_e;

  // Field values loaded for a bubble (flush or invalid MEM input)
  localparam logic [1:0] NopWdSel  = 2'b00;
  localparam logic       NopValid  = 1'b0;
  localparam logic       NopRfWe   = 1'b0;

endpackage

// File: rtl/mem_wb_reg_if.sv
// MEM->WB bus: control, MEM-stage results and registered WB-stage outputs.
// Trace/debug signals exist only when WB_TRACE_EN is defined.
interface mem_wb_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);

  logic              stall;
  logic              flush;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_pc;
  logic [DATA_W-1:0] mem_pc4;
  logic [DATA_W-1:0] mem_imm;
  logic [DATA_W-1:0] mem_alu_c;
  logic [DATA_W-1:0] mem_dram_rd;
  logic [1:0]        mem_wd_sel;
  logic              mem_rf_we;
  logic [REG_AW-1:0] mem_wr;

  logic              wb_valid;
  logic [DATA_W-1:0] wb_pc4;
  logic [DATA_W-1:0] wb_imm;
  logic [DATA_W-1:0] wb_alu_c;
  logic [DATA_W-1:0] wb_dram_rd;
  logic [1:0]        wb_wd_sel;
  logic [REG_AW-1:0] wb_wr;
  logic              wb_rf_we;

`ifdef WB_TRACE_EN
  logic [DATA_W-1:0] wb_wd;
  logic              debug_wb_have_inst;
  logic [DATA_W-1:0] debug_wb_pc;
  logic              debug_wb_ena;
  logic [REG_AW-1:0] debug_wb_reg;
  logic [DATA_W-1:0] debug_wb_value;
  logic [31:0]       retire_cnt;
`endif

  modport master (
    output stall, flush, mem_valid, mem_pc, mem_pc4, mem_imm, mem_alu_c, mem_dram_rd,
           mem_wd_sel, mem_rf_we, mem_wr,
`ifdef WB_TRACE_EN
    output wb_wd,
    input  debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value,
           retire_cnt,
`endif
    input  wb_valid, wb_pc4, wb_imm, wb_alu_c, wb_dram_rd, wb_wd_sel, wb_wr, wb_rf_we
  );

  modport slave (
    input  stall, flush, mem_valid, mem_pc, mem_pc4, mem_imm, mem_alu_c, mem_dram_rd,
           mem_wd_sel, mem_rf_we, mem_wr,
`ifdef WB_TRACE_EN
    input  wb_wd,
    output debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value,
           retire_cnt,
`endif
    output wb_valid, wb_pc4, wb_imm, wb_alu_c, wb_dram_rd, wb_wd_sel, wb_wr, wb_rf_we
  );

endinterface

// File: rtl/mem_wb_reg_pipe_dff.sv
// Pipeline field register: synchronous reset, clear (bubble) takes priority over enable.
module mem_wb_reg_pipe_dff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= '0;
    end else if (i_clr) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/mem_wb_reg.sv
// MEM->WB pipeline register with bubble/flush/stall handling and write-once RF enable.
// Defining WB_TRACE_EN adds the debug trace outputs, a registered PC and a retire counter.
module mem_wb_reg
  import mem_wb_reg_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input logic         clk,
  input logic         rst,
  mem_wb_reg_if.slave bus
);

  logic              w_en;
  logic              w_ld_valid;
  logic              w_ld_rf_we;
  logic [REG_AW-1:0] w_ld_wr;
  logic [1:0]        w_ld_wd_sel;
  logic [DATA_W-1:0] w_ld_pc4;
  logic [DATA_W-1:0] w_ld_imm;
  logic [DATA_W-1:0] w_ld_alu_c;
  logic [DATA_W-1:0] w_ld_dram_rd;

  logic              r_valid;
  logic              r_rf_we;
  logic              r_fresh;
  logic [REG_AW-1:0] r_wr;
  logic [1:0]        r_wd_sel;
  logic [DATA_W-1:0] r_pc4;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_alu_c;
  logic [DATA_W-1:0] r_dram_rd;

  assign w_en = ~bus.stall;

  // An invalid MEM slot loads exactly like a flush bubble, whatever its control bits say.
  always_comb begin
    w_ld_valid   = bus.mem_valid;
    w_ld_rf_we   = bus.mem_rf_we;
    w_ld_wr      = bus.mem_wr;
    w_ld_wd_sel  = bus.mem_wd_sel;
    w_ld_pc4     = bus.mem_pc4;
    w_ld_imm     = bus.mem_imm;
    w_ld_alu_c   = bus.mem_alu_c;
    w_ld_dram_rd = bus.mem_dram_rd;
    if (!bus.mem_valid) begin
      w_ld_valid   = NopValid;
      w_ld_rf_we   = NopRfWe;
      w_ld_wr      = '0;
      w_ld_wd_sel  = NopWdSel;
      w_ld_pc4     = '0;
      w_ld_imm     = '0;
      w_ld_alu_c   = '0;
      w_ld_dram_rd = '0;
    end
  end

  mem_wb_reg_pipe_dff #(.W(1)) u_valid (
    .clk(clk), .rst(rst), .i_en(w_en), .i_clr(bus.flush), .i_d(w_ld_valid), .o_q(r_valid)
  );
  mem_wb_reg_pipe_dff #(.W(1)) u_rf_we (
    .clk(clk), .rst(rst), .i_en(w_en), .i_clr(bus.flush), .i_d(w_ld_rf_we), .o_q(r_rf_we)
  );
  mem_wb_reg_pipe_dff #(.W(REG_AW)) u_wr (
    .clk(clk), .rst(rst), .i_en(w_en), .i_clr(bus.flush), .i_d(w_ld_wr), .o_q(r_wr)
  );
  mem_wb_reg_pipe_dff #(.W(2)) u_wd_sel (
    .clk(clk), .rst(rst), .i_en(w_en), .i_clr(bus.flush), .i_d(w_ld_wd_sel), .o_q(r_wd_sel)
  );
  mem_wb_reg_pipe_dff #(.W(DATA_W)) u_pc4 (
    .clk(clk), .rst(rst), .i_en(w_en), .i_clr(bus.flush), .i_d(w_ld_pc4), .o_q(r_pc4)
  );
  mem_wb_reg_pipe_dff #(.W(DATA_W)) u_imm (
    .clk(clk), .rst(rst), .i_en(w_en), .i_clr(bus.flush), .i_d(w_ld_imm), .o_q(r_imm)
  );
  mem_wb_reg_pipe_dff #(.W(DATA_W)) u_alu_c (
    .clk(clk), .rst(rst), .i_en(w_en), .i_clr(bus.flush), .i_d(w_ld_alu_c), .o_q(r_alu_c)
  );
  mem_wb_reg_pipe_dff #(.W(DATA_W)) u_dram_rd (
    .clk(clk), .rst(rst), .i_en(w_en), .i_clr(bus.flush), .i_d(w_ld_dram_rd), .o_q(r_dram_rd)
  );

  // Set only on the cycle a new slot is loaded, so a stalled instruction writes back once.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fresh <= 1'b0;
    end else begin
      r_fresh <= ~(bus.flush | bus.stall);
    end
  end

  assign bus.wb_valid   = r_valid;
  assign bus.wb_wr      = r_wr;
  assign bus.wb_wd_sel  = r_wd_sel;
  assign bus.wb_pc4     = r_pc4;
  assign bus.wb_imm     = r_imm;
  assign bus.wb_alu_c   = r_alu_c;
  assign bus.wb_dram_rd = r_dram_rd;
  assign bus.wb_rf_we   = r_valid & r_rf_we & r_fresh & (r_wr != '0);

`ifdef WB_TRACE_EN
  logic [DATA_W-1:0] w_ld_pc;
  logic [DATA_W-1:0] r_pc;
  logic              w_have_inst;
  logic [31:0]       r_retire_cnt;

  assign w_ld_pc = bus.mem_valid ? bus.mem_pc : '0;

  mem_wb_reg_pipe_dff #(.W(DATA_W)) u_pc (
    .clk(clk), .rst(rst), .i_en(w_en), .i_clr(bus.flush), .i_d(w_ld_pc), .o_q(r_pc)
  );

  assign w_have_inst = r_valid & r_fresh;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= '0;
    end else if (w_have_inst) begin
      r_retire_cnt <= r_retire_cnt + 32'd1;
    end
  end

  assign bus.debug_wb_have_inst = w_have_inst;
  assign bus.debug_wb_pc        = r_pc;
  assign bus.debug_wb_ena       = bus.wb_rf_we;
  assign bus.debug_wb_reg       = r_wr;
  assign bus.debug_wb_value     = bus.wb_wd;
  assign bus.retire_cnt         = r_retire_cnt;
`endif

endmodule
